// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the BCD frequency meter.
// Pure declarations: no logic, no latency, no flow control.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LATCH   = 2'd2
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/freq_meter_bcd_cell.sv
// One decade (0..9) of the BCD edge accumulator; carry_out is combinational so the ripple settles in one cycle.
// Updates on the clock after inc/clear/load1; no backpressure, sat_hold freezes the digit at saturation.
module bcd_digit_cell
    import freq_meter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load1,
    input  logic             inc,
    input  logic             sat_hold,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else if (clear) begin
            digit <= '0;
        end else if (load1) begin
            digit <= 4'd1;
        end else if (inc && !sat_hold) begin
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
        end
    end

    assign carry_out = (digit == BCD_MAX) && inc;

endmodule

// File: rtl/freq_meter_bcd.sv
// Counts sig_in rising edges over GATE_CYCLES clocks and publishes the total as packed BCD.
// Result and valid appear one clock after the LATCH cycle; no backpressure, every window result is published.
module freq_meter_bcd
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50000000,
    parameter int GW          = 26,
    parameter int DIGITS      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    sig_in,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    valid,
    output logic                    overflow,
    output logic                    busy
);

    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 2);

    logic                    s1, s2, s3;
    logic                    sig_edge;
    state_t                  state, state_nxt;
    logic                    in_idle, in_measure, in_latch;
    logic [GW-1:0]           gate_cnt;
    logic                    sat_flag;
    logic [BCD_W*DIGITS-1:0] acc;
    logic [DIGITS:0]         inc_chain;
    logic                    all_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_idle    = 1'b0;
        in_measure = 1'b0;
        in_latch   = 1'b0;
        case (state)
            IDLE: begin
                in_idle = 1'b1;
                if (en) state_nxt = MEASURE;
            end
            MEASURE: begin
                in_measure = 1'b1;
                if (!en)                        state_nxt = IDLE;
                else if (gate_cnt == GATE_LAST) state_nxt = LATCH;
            end
            LATCH: begin
                in_latch  = 1'b1;
                state_nxt = en ? MEASURE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only advance while the window continues, so IDLE always sees a zero count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (in_measure && state_nxt == MEASURE) begin
            gate_cnt <= gate_cnt + GW'(1);
        end else begin
            gate_cnt <= '0;
        end
    end

    // The edge seen during LATCH seeds the next window through digit 0's load1.
    assign inc_chain[0] = in_measure & sig_edge;
    assign all_sat      = inc_chain[DIGITS];

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic cell_clear;
        logic cell_load1;

        if (k == 0) begin : g_lsd
            assign cell_clear = in_idle | (in_latch & ~sig_edge);
            assign cell_load1 = in_latch & sig_edge;
        end else begin : g_upper
            assign cell_clear = in_idle | in_latch;
            assign cell_load1 = 1'b0;
        end

        bcd_digit_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .clear     (cell_clear),
            .load1     (cell_load1),
            .inc       (inc_chain[k]),
            .sat_hold  (all_sat),
            .digit     (acc[k*BCD_W +: BCD_W]),
            .carry_out (inc_chain[k+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (!in_measure) begin
            sat_flag <= 1'b0;
        end else if (all_sat) begin
            sat_flag <= 1'b1;
        end
    end

    // valid is registered so it coincides with the new bcd_out value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_out  <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= in_latch;
            if (in_latch) begin
                bcd_out  <= acc;
                overflow <= sat_flag;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
